// File: rtl/flag_cond_unit_if.sv
// ----------------------------------------------------------------------------
// flag_cond_unit_if
// Bundles the flag/condition/stack signals between the producer side
// (ALU flags, decoder requests) and the flag_cond_unit.
//   master : drives flag_we, z, v, n, c, eval_req, cond, push, pop;
//            observes taken, taken_vld, stk_full, stk_empty, stk_err, flags_out
//   slave  : the flag_cond_unit itself (mirror directions)
// ----------------------------------------------------------------------------
interface flag_cond_unit_if;
   logic       flag_we;
   logic       z;
   logic       v;
   logic       n;
   logic       c;
   logic       eval_req;
   logic [3:0] cond;
   logic       push;
   logic       pop;
   logic       taken;
   logic       taken_vld;
   logic       stk_full;
   logic       stk_empty;
   logic       stk_err;
   logic [3:0] flags_out;

   modport master (
      output flag_we, z, v, n, c, eval_req, cond, push, pop,
      input  taken, taken_vld, stk_full, stk_empty, stk_err, flags_out
   );

   modport slave (
      input  flag_we, z, v, n, c, eval_req, cond, push, pop,
      output taken, taken_vld, stk_full, stk_empty, stk_err, flags_out
   );
endinterface

// File: rtl/flag_cond_unit.sv
// ----------------------------------------------------------------------------
// flag_cond_unit
// Committed Z/V/N (optionally C) flag register with a branch-condition
// evaluator, same-cycle bypass and a flag save/restore stack.
//
// Parameters:
//   STACK_DEPTH : number of flag-save entries (>= 1)
//   BYPASS      : 1 -> an evaluation in a flag_we cycle (without pop) sees
//                 the incoming flags; 0 -> it always sees committed flags
// Configuration macro:
//   FLAG_CARRY_EN : when defined, a carry bit is stored/stacked, reported on
//                   flags_out[3], and cond[3]=1 selects unsigned conditions.
//                   When undefined, c and cond[3] are ignored.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (priority over every input)
//   bus  : flag_cond_unit_if.slave
//          inputs  flag_we, z, v, n, c, eval_req, cond[3:0], push, pop
//          outputs taken, taken_vld, stk_full, stk_empty, stk_err,
//                  flags_out[3:0] = {c,z,v,n}
// ----------------------------------------------------------------------------
module flag_cond_unit #(
   parameter int STACK_DEPTH = 4,
   parameter int BYPASS      = 1
) (
   input logic              clk,
   input logic              rst,
   flag_cond_unit_if.slave  bus
);

`ifdef FLAG_CARRY_EN
   localparam int FW = 4;
`else
   localparam int FW = 3;
`endif
   // Pointer counts 0..STACK_DEPTH, the slot index only needs 0..STACK_DEPTH-1.
   localparam int PW    = $clog2(STACK_DEPTH + 1);
   localparam int IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int SLOTS = 1 << IW;
   localparam logic [PW-1:0] DEPTH_P = PW'(STACK_DEPTH);

   logic [FW-1:0] r_flags;
   logic [FW-1:0] r_stack [SLOTS];
   logic [PW-1:0] r_ptr;
   logic          r_full;
   logic          r_empty;
   logic          r_err;
   logic          r_taken;
   logic          r_vld;

   logic [FW-1:0] w_flags_in;
   logic [FW-1:0] w_flags_nxt;
   logic [PW-1:0] w_ptr_nxt;
   logic [IW-1:0] w_top_idx;
   logic [IW-1:0] w_pop_idx;
   logic          w_push_ok;
   logic          w_pop_ok;
   logic          w_stk_fault;
   logic [3:0]    w_eval_flags;
   logic [3:0]    w_cond;
   logic          w_taken_nxt;

   // Condition decode; f is {c,z,v,n}. Codes 11xx are reserved.
   function automatic logic f_eval(input logic [3:0] cnd, input logic [3:0] f);
      logic fc;
      logic fz;
      logic fv;
      logic fn;
      fc = f[3];
      fz = f[2];
      fv = f[1];
      fn = f[0];
      case (cnd)
         4'b0000: f_eval = fz;
         4'b0001: f_eval = fn & ~fv;
         4'b0010: f_eval = ~fz & ~fv & ~fn;
         4'b0011: f_eval = fv;
         4'b0100: f_eval = ~fz;
         4'b0101: f_eval = fv | ~fn;
         4'b0110: f_eval = (fn & ~fv) | fz;
         4'b0111: f_eval = 1'b1;
         4'b1000: f_eval = fc;
         4'b1001: f_eval = ~fc;
         4'b1010: f_eval = ~fc & ~fz;
         4'b1011: f_eval = fc | fz;
         default: f_eval = 1'b0;
      endcase
   endfunction

`ifdef FLAG_CARRY_EN
   assign w_flags_in    = {bus.c, bus.z, bus.v, bus.n};
   assign w_cond        = bus.cond;
   assign bus.flags_out = r_flags;
`else
   logic w_unused;
   assign w_unused      = &{1'b0, bus.c, bus.cond[3]};
   assign w_flags_in    = {bus.z, bus.v, bus.n};
   // Forcing cond[3] low keeps the signed table regardless of the input.
   assign w_cond        = {1'b0, bus.cond[2:0]};
   assign bus.flags_out = {1'b0, r_flags};
`endif

   assign w_top_idx = r_ptr[IW-1:0];
   assign w_pop_idx = w_top_idx - IW'(1'b1);

   // Stack/pointer next-state, flag next-state and condition evaluation.
   always_comb begin
      w_push_ok    = 1'b0;
      w_pop_ok     = 1'b0;
      w_stk_fault  = 1'b0;
      w_ptr_nxt    = r_ptr;
      w_flags_nxt  = r_flags;
      w_eval_flags = 4'b0000;
      w_taken_nxt  = r_taken;

      // push+pop together cancel out: no movement and no error.
      if (bus.push && !bus.pop) begin
         w_push_ok   = ~r_full;
         w_stk_fault = r_full;
      end else if (bus.pop && !bus.push) begin
         w_pop_ok    = ~r_empty;
         w_stk_fault = r_empty;
      end else begin
         w_stk_fault = 1'b0;
      end

      if (w_push_ok) begin
         w_ptr_nxt = r_ptr + PW'(1'b1);
      end else if (w_pop_ok) begin
         w_ptr_nxt = r_ptr - PW'(1'b1);
      end else begin
         w_ptr_nxt = r_ptr;
      end

      // A successful pop beats flag_we; a failed pop leaves flag_we in force.
      if (w_pop_ok) begin
         w_flags_nxt = r_stack[w_pop_idx];
      end else if (bus.flag_we) begin
         w_flags_nxt = w_flags_in;
      end else begin
         w_flags_nxt = r_flags;
      end

      // Bypass keys off the raw pop input, not on whether the pop succeeded.
      if ((BYPASS != 0) && bus.flag_we && !bus.pop) begin
         w_eval_flags = 4'(w_flags_in);
      end else begin
         w_eval_flags = 4'(r_flags);
      end

      if (bus.eval_req) begin
         w_taken_nxt = f_eval(w_cond, w_eval_flags);
      end else begin
         w_taken_nxt = r_taken;
      end
   end

   // Control and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags <= {FW{1'b0}};
         r_ptr   <= {PW{1'b0}};
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_err   <= 1'b0;
         r_taken <= 1'b0;
         r_vld   <= 1'b0;
      end else begin
         r_flags <= w_flags_nxt;
         r_ptr   <= w_ptr_nxt;
         r_full  <= (w_ptr_nxt == DEPTH_P);
         r_empty <= (w_ptr_nxt == {PW{1'b0}});
         r_err   <= r_err | w_stk_fault;
         r_taken <= w_taken_nxt;
         r_vld   <= bus.eval_req;
      end
   end

   // Stack storage; contents are only meaningful below the pointer.
   always_ff @(posedge clk) begin
      if (!rst && w_push_ok) begin
         r_stack[w_top_idx] <= r_flags;
      end
   end

   assign bus.taken     = r_taken;
   assign bus.taken_vld = r_vld;
   assign bus.stk_full  = r_full;
   assign bus.stk_empty = r_empty;
   assign bus.stk_err   = r_err;

endmodule

// File: tb/tb_flag_cond_unit.sv
// ----------------------------------------------------------------------------
// tb_flag_cond_unit
// Drives two instances with identical stimulus: dut_a (STACK_DEPTH=4,
// BYPASS=1) and dut_b (STACK_DEPTH=2, BYPASS=0). A behavioural model
// (flag value, array-backed stack with a count) predicts every output.
// Directed steps come first, then randomized cycles.
// ----------------------------------------------------------------------------
module tb_flag_cond_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   flag_cond_unit_if bus_a ();
   flag_cond_unit_if bus_b ();

   flag_cond_unit #(.STACK_DEPTH(4), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   flag_cond_unit #(.STACK_DEPTH(2), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int checks = 0;
   int errors = 0;

   // current stimulus
   logic       s_we, s_z, s_v, s_n, s_c, s_er, s_push, s_pop, s_rst;
   logic [3:0] s_cond;

   // model state, index 0 -> dut_a, 1 -> dut_b
   logic [3:0] m_flags [2];
   logic [3:0] m_stk   [2][8];
   int         m_cnt   [2];
   logic       m_taken [2];
   logic       m_vld   [2];
   logic       m_err   [2];

   function automatic int depth_of(input int i);
      return (i == 0) ? 4 : 2;
   endfunction

   function automatic logic [3:0] in_flags();
`ifdef FLAG_CARRY_EN
      return {s_c, s_z, s_v, s_n};
`else
      return {1'b0, s_z, s_v, s_n};
`endif
   endfunction

   // Reference condition meaning, flags f = {c,z,v,n}
   function automatic logic ref_cond(input logic [3:0] cnd, input logic [3:0] f);
      logic lt;
      lt = f[0] & ~f[1];
`ifdef FLAG_CARRY_EN
      if (cnd[3]) begin
         case (cnd[2:0])
            3'd0: return f[3];
            3'd1: return !f[3];
            3'd2: return !f[3] && !f[2];
            3'd3: return f[3] || f[2];
            default: return 1'b0;
         endcase
      end
`endif
      case (cnd[2:0])
         3'd0: return f[2];
         3'd1: return lt;
         3'd2: return !f[2] && !f[1] && !f[0];
         3'd3: return f[1];
         3'd4: return !f[2];
         3'd5: return !lt;
         3'd6: return lt || f[2];
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_step(input int i);
      logic [3:0] old;
      logic [3:0] src;
      logic       popped;
      if (s_rst) begin
         m_flags[i] = 4'd0; m_cnt[i] = 0; m_taken[i] = 1'b0;
         m_vld[i] = 1'b0; m_err[i] = 1'b0;
      end else begin
         old    = m_flags[i];
         popped = 1'b0;
         src    = ((i == 0) && s_we && !s_pop) ? in_flags() : old;
         if (s_er) m_taken[i] = ref_cond(s_cond, src);
         m_vld[i] = s_er;
         if (s_push && !s_pop) begin
            if (m_cnt[i] == depth_of(i)) m_err[i] = 1'b1;
            else begin m_stk[i][m_cnt[i]] = old; m_cnt[i]++; end
         end else if (s_pop && !s_push) begin
            if (m_cnt[i] == 0) m_err[i] = 1'b1;
            else begin m_cnt[i]--; m_flags[i] = m_stk[i][m_cnt[i]]; popped = 1'b1; end
         end
         if (!popped && s_we) m_flags[i] = in_flags();
      end
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rs, input logic we, input logic [3:0] zvnc,
                        input logic er, input logic [3:0] cnd, input logic pu, input logic po);
      s_rst = rs; s_we = we; s_z = zvnc[3]; s_v = zvnc[2]; s_n = zvnc[1]; s_c = zvnc[0];
      s_er = er; s_cond = cnd; s_push = pu; s_pop = po;
      rst = rs;
      bus_a.flag_we = we; bus_a.z = s_z; bus_a.v = s_v; bus_a.n = s_n; bus_a.c = s_c;
      bus_a.eval_req = er; bus_a.cond = cnd; bus_a.push = pu; bus_a.pop = po;
      bus_b.flag_we = we; bus_b.z = s_z; bus_b.v = s_v; bus_b.n = s_n; bus_b.c = s_c;
      bus_b.eval_req = er; bus_b.cond = cnd; bus_b.push = pu; bus_b.pop = po;
   endtask

   // one clock: model follows the edge, outputs compared 1 time unit later
   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check("a_taken", {3'd0, bus_a.taken},     {3'd0, m_taken[0]});
      check("a_vld",   {3'd0, bus_a.taken_vld}, {3'd0, m_vld[0]});
      check("a_flags", bus_a.flags_out,         m_flags[0]);
      check("a_full",  {3'd0, bus_a.stk_full},  {3'd0, m_cnt[0] == 4});
      check("a_empty", {3'd0, bus_a.stk_empty}, {3'd0, m_cnt[0] == 0});
      check("a_err",   {3'd0, bus_a.stk_err},   {3'd0, m_err[0]});
      check("b_taken", {3'd0, bus_b.taken},     {3'd0, m_taken[1]});
      check("b_vld",   {3'd0, bus_b.taken_vld}, {3'd0, m_vld[1]});
      check("b_flags", bus_b.flags_out,         m_flags[1]);
      check("b_full",  {3'd0, bus_b.stk_full},  {3'd0, m_cnt[1] == 2});
      check("b_empty", {3'd0, bus_b.stk_empty}, {3'd0, m_cnt[1] == 0});
      check("b_err",   {3'd0, bus_b.stk_err},   {3'd0, m_err[1]});
   endtask

   // zvnc argument order: {z, v, n, c}
   initial begin
      // 1. reset with a pending eval, then AL
      drive(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0111, 1'b0, 1'b0); tick();
      check("t1_rst_vld",   {3'd0, bus_a.taken_vld}, 4'd0);
      check("t1_rst_flags", bus_a.flags_out, 4'b0000);
      check("t1_rst_empty", {3'd0, bus_a.stk_empty}, 4'd1);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0111, 1'b0, 1'b0); tick();
      check("t1_al_taken", {3'd0, bus_a.taken}, 4'd1);
      check("t1_al_vld",   {3'd0, bus_a.taken_vld}, 4'd1);

      // 2. commit n=1, then LT/GE/LE
      drive(1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0); tick();
      check("t2_lt", {3'd0, bus_a.taken}, 4'd1);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0101, 1'b0, 1'b0); tick();
      check("t2_ge", {3'd0, bus_a.taken}, 4'd0);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b0); tick();
      check("t2_le", {3'd0, bus_a.taken}, 4'd1);
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0); tick();
      check("t2_hold", {3'd0, bus_a.taken}, 4'd1);

      // 3. bypass vs no bypass
      drive(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0); tick();
      check("t3_byp1", {3'd0, bus_a.taken}, 4'd1);
      check("t3_byp0", {3'd0, bus_b.taken}, 4'd0);

      // 4. stack context
      drive(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
      check("t4_pop1", bus_a.flags_out, 4'b0000);
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
      check("t4_pop2", bus_a.flags_out, 4'b0100);
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
      check("t4_err",   {3'd0, bus_a.stk_err}, 4'd1);
      check("t4_keep",  bus_a.flags_out, 4'b0100);

      // 5. depth-2 instance: fill, overflow, push+pop, pop beats flag_we
      drive(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
      check("t5_full", {3'd0, bus_b.stk_full}, 4'd1);
      check("t5_noerr", {3'd0, bus_b.stk_err}, 4'd0);
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
      check("t5_ovf", {3'd0, bus_b.stk_err}, 4'd1);
      check("t5_full2", {3'd0, bus_b.stk_full}, 4'd1);
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1); tick();
      check("t5_pp_full", {3'd0, bus_b.stk_full}, 4'd1);
      check("t5_pp_flags", bus_b.flags_out, 4'b0010);
      drive(1'b0, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
      check("t5_popwin", bus_b.flags_out, 4'b0010);
      check("t5_notfull", {3'd0, bus_b.stk_full}, 4'd0);

      // 6. unsigned conditions / cond[3] ignored
      drive(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
`ifdef FLAG_CARRY_EN
      drive(1'b0, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      check("t6_cflag", bus_a.flags_out, 4'b1000);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0); tick();
      check("t6_ltu", {3'd0, bus_a.taken}, 4'd1);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1001, 1'b0, 1'b0); tick();
      check("t6_geu", {3'd0, bus_a.taken}, 4'd0);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1010, 1'b0, 1'b0); tick();
      check("t6_gtu", {3'd0, bus_a.taken}, 4'd0);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1011, 1'b0, 1'b0); tick();
      check("t6_leu", {3'd0, bus_a.taken}, 4'd1);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100, 1'b0, 1'b0); tick();
      check("t6_rsv", {3'd0, bus_a.taken}, 4'd0);
`else
      drive(1'b0, 1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
      check("t6_noc", bus_a.flags_out, 4'b0100);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0); tick();
      check("t6_eq", {3'd0, bus_a.taken}, 4'd1);
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1100, 1'b0, 1'b0); tick();
      check("t6_ne", {3'd0, bus_a.taken}, 4'd0);
`endif

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
               1'($urandom_range(0, 1)), 4'($urandom),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
